// File: rtl/elevator_queue_ctrl.sv
// Elevator request sequencer: FIFO of floor requests with duplicate drop,
// one-level-at-a-time car movement toward the head and timed door service.
// Ports: clk, rst_n (sync, active-low); req_valid/req_lvl/req_ready request
// handshake; pos_lvl car level; head_lvl/queue_count queue view;
// moving/dir_up/door_open car and door drive.
module elevator_queue_ctrl #(
  parameter  int LVL_W       = 2,
  parameter  int DEPTH       = 4,
  parameter  int MOVE_CYCLES = 8,
  parameter  int DOOR_CYCLES = 4,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [LVL_W-1:0] req_lvl,
  output logic             req_ready,
  output logic [LVL_W-1:0] pos_lvl,
  output logic [LVL_W-1:0] head_lvl,
  output logic [CNT_W-1:0] queue_count,
  output logic             moving,
  output logic             dir_up,
  output logic             door_open
);

  localparam int TMAX  = (MOVE_CYCLES > DOOR_CYCLES) ?
                         MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TMR_W-1:0] MOVE_T = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DOOR_T = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_ONE  = TMR_W'(1);
  localparam logic [LVL_W-1:0] L_ONE  = LVL_W'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [LVL_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] q_q [DEPTH];
  logic [LVL_W-1:0] q_d [DEPTH];

  logic             pop;
  logic             dup;
  logic             store;
  logic [LVL_W-1:0] npos;
  logic [CNT_W-1:0] widx;

  assign req_ready   = (cnt_q < C_FULL);
  assign pos_lvl     = pos_q;
  assign head_lvl    = q_q[0];
  assign queue_count = cnt_q;
  assign moving      = (state_q == MOVE);
  assign dir_up      = dir_q;
  assign door_open   = (state_q == DOOR);

  // Car / door sequencer; the head is stable until the DOOR pop.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    pop     = 1'b0;
    npos    = pos_q;
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          if (q_q[0] == pos_q) begin
            state_d = DOOR;
            tmr_d   = DOOR_T;
          end else begin
            state_d = MOVE;
            tmr_d   = MOVE_T;
            dir_d   = (q_q[0] > pos_q);
          end
        end
      end
      MOVE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - T_ONE;
        end else begin
          npos  = dir_q ? (pos_q + L_ONE) : (pos_q - L_ONE);
          pos_d = npos;
          if (npos == q_q[0]) begin
            state_d = DOOR;
            tmr_d   = DOOR_T;
          end else begin
            tmr_d = MOVE_T;
            dir_d = (q_q[0] > npos);
          end
        end
      end
      DOOR: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - T_ONE;
        end else begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request queue: the head being popped this cycle no longer
  // counts as a duplicate, so a same-level request is re-queued.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && !(pop && (i == 0)) &&
          (q_q[i] == req_lvl)) begin
        dup = 1'b1;
      end
    end
    store = req_valid && req_ready && !dup;
    widx  = pop ? (cnt_q - C_ONE) : cnt_q;

    for (int i = 0; i < DEPTH; i++) begin
      q_d[i] = q_q[i];
    end
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        q_d[i] = q_q[i+1];
      end
      q_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (store && (CNT_W'(i) == widx)) begin
        q_d[i] = req_lvl;
      end
    end

    cnt_d = cnt_q;
    if (store && !pop) begin
      cnt_d = cnt_q + C_ONE;
    end else if (pop && !store) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// Bench for elevator_queue_ctrl: directed scenarios plus random traffic,
// checked by a cycle-level scoreboard fed from a queue-based reference model.
module tb_elevator_queue_ctrl;

  localparam int LW = 2;
  localparam int DP = 4;
  localparam int MC = 2;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [LW-1:0] req_lvl = '0;
  logic          req_ready;
  logic [LW-1:0] pos_lvl;
  logic [LW-1:0] head_lvl;
  logic [2:0]    queue_count;
  logic          moving;
  logic          dir_up;
  logic          door_open;

  elevator_queue_ctrl #(
    .LVL_W(LW), .DEPTH(DP), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_lvl(req_lvl), .req_ready(req_ready),
    .pos_lvl(pos_lvl), .head_lvl(head_lvl), .queue_count(queue_count),
    .moving(moving), .dir_up(dir_up), .door_open(door_open)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic check(string n, int got, int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d", n, got, exp);
  endtask

  // Reference model: request list as a plain queue, car as level + countdown.
  int m_st;
  int m_tmr;
  int m_pos;
  int m_dir;
  int mq[$];

  typedef struct {
    int pos; int head; int cnt; int mv; int dir; int door; int rdy;
  } exp_t;
  exp_t sb[$];

  function automatic void model_step(bit r, bit v, int lvl);
    bit pop;
    bit dup;
    bit rdy;
    int head;
    if (!r) begin
      mq.delete();
      m_st = 0; m_tmr = 0; m_pos = 0; m_dir = 0;
      return;
    end
    pop  = (m_st == 2) && (m_tmr == 0);
    head = (mq.size() != 0) ? mq[0] : 0;
    rdy  = (mq.size() < DP);
    dup  = 1'b0;
    foreach (mq[j]) if (mq[j] == lvl && !(pop && j == 0)) dup = 1'b1;
    case (m_st)
      0: if (mq.size() != 0) begin
        if (head == m_pos) begin m_st = 2; m_tmr = DC - 1; end
        else begin
          m_st = 1; m_tmr = MC - 1; m_dir = (head > m_pos) ? 1 : 0;
        end
      end
      1: if (m_tmr != 0) m_tmr--;
      else begin
        m_pos += (m_dir != 0) ? 1 : -1;
        if (m_pos == head) begin m_st = 2; m_tmr = DC - 1; end
        else begin m_tmr = MC - 1; m_dir = (head > m_pos) ? 1 : 0; end
      end
      default: if (m_tmr != 0) m_tmr--; else m_st = 0;
    endcase
    if (pop) void'(mq.pop_front());
    if (v && rdy && !dup) mq.push_back(lvl);
  endfunction

  task automatic cyc(bit r, bit v, int lvl);
    exp_t e;
    rst_n = r; req_valid = v; req_lvl = LW'(lvl);
    @(posedge clk);
    #1;
    model_step(r, v, lvl);
    e.pos  = m_pos;
    e.head = (mq.size() != 0) ? mq[0] : 0;
    e.cnt  = mq.size();
    e.mv   = (m_st == 1);
    e.dir  = m_dir;
    e.door = (m_st == 2);
    e.rdy  = (mq.size() < DP);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_pos", int'(pos_lvl), e.pos);
      check("sb_head", int'(head_lvl), e.head);
      check("sb_count", int'(queue_count), e.cnt);
      check("sb_moving", int'(moving), e.mv);
      check("sb_dir", int'(dir_up), e.dir);
      check("sb_door", int'(door_open), e.door);
      check("sb_ready", int'(req_ready), e.rdy);
    end
  end

  bit trk = 1'b0;
  bit p_door = 1'b0;
  bit p_mv = 1'b0;
  int visits[$];
  int dirs[$];

  always @(negedge clk) begin
    if (trk) begin
      if (door_open && !p_door) visits.push_back(int'(pos_lvl));
      if (moving && !p_mv) dirs.push_back(int'(dir_up));
    end
    p_door = door_open;
    p_mv   = moving;
  end

  task automatic chk_zero(string n);
    check({n, "_pos"}, int'(pos_lvl), 0);
    check({n, "_head"}, int'(head_lvl), 0);
    check({n, "_cnt"}, int'(queue_count), 0);
    check({n, "_mv"}, int'(moving), 0);
    check({n, "_dir"}, int'(dir_up), 0);
    check({n, "_door"}, int'(door_open), 0);
    check({n, "_rdy"}, int'(req_ready), 1);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  initial begin
    // reset and mid-move reset
    do_reset();
    chk_zero("rst");
    cyc(1, 1, 3);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("midmove_mv", int'(moving), 1);
    cyc(0, 0, 0);
    chk_zero("midrst");

    // single request two levels up
    cyc(1, 1, 2);
    check("t2_cnt_t", int'(queue_count), 1);
    cyc(1, 0, 0);
    check("t2_mv_t1", int'(moving), 1);
    check("t2_dir_t1", int'(dir_up), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t2_pos_t3", int'(pos_lvl), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t2_pos_t5", int'(pos_lvl), 2);
    check("t2_door_t5", int'(door_open), 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t2_door_t7", int'(door_open), 0);
    check("t2_cnt_t7", int'(queue_count), 0);

    // duplicate drop and visiting order
    do_reset();
    trk = 1'b1;
    cyc(1, 1, 3);
    cyc(1, 1, 1);
    cyc(1, 1, 3);
    cyc(1, 1, 0);
    check("t3_cnt", int'(queue_count), 3);
    check("t3_head", int'(head_lvl), 3);
    for (int i = 0; i < 100 && queue_count != 0; i++) cyc(1, 0, 0);
    trk = 1'b0;
    check("t3_nvisit", visits.size(), 3);
    check("t3_ndir", dirs.size(), 3);
    if (visits.size() == 3) begin
      check("t3_v0", visits[0], 3);
      check("t3_v1", visits[1], 1);
      check("t3_v2", visits[2], 0);
    end
    if (dirs.size() == 3) begin
      check("t3_d0", dirs[0], 1);
      check("t3_d1", dirs[1], 0);
      check("t3_d2", dirs[2], 0);
    end

    // full queue
    do_reset();
    cyc(1, 1, 1);
    cyc(1, 1, 2);
    cyc(1, 1, 3);
    cyc(1, 1, 0);
    check("t4_cnt", int'(queue_count), 4);
    check("t4_rdy", int'(req_ready), 0);
    cyc(1, 1, 2);
    check("t4_cnt_ign", int'(queue_count), 4);
    cyc(1, 1, 2);
    check("t4_cnt_pop", int'(queue_count), 3);
    check("t4_rdy_pop", int'(req_ready), 1);
    cyc(1, 0, 0);

    // push on the pop edge of the same level
    do_reset();
    cyc(1, 1, 2);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    check("t5_door_pre", int'(door_open), 1);
    cyc(1, 1, 2);
    check("t5_cnt", int'(queue_count), 1);
    check("t5_head", int'(head_lvl), 2);
    check("t5_idle", int'(door_open), 0);
    cyc(1, 0, 0);
    check("t5_reopen", int'(door_open), 1);

    // request at current level
    do_reset();
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    check("t6_door_t1", int'(door_open), 1);
    cyc(1, 0, 0);
    check("t6_door_t2", int'(door_open), 1);
    cyc(1, 0, 0);
    check("t6_door_t3", int'(door_open), 0);
    check("t6_cnt_t3", int'(queue_count), 0);
    check("t6_pos", int'(pos_lvl), 0);
    check("t6_mv", int'(moving), 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) != 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 3)));
    end
    cyc(1, 0, 0);
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
